frame_buffer_arbiter: RTL

Owns the single-port frame-buffer SRAM and shares it between the frame displayer (reads, strict priority) and the sprite/draw engine (writes, valid/ready). Manages double buffering: the displayer always reads the front buffer, the draw engine always writes the back buffer, and buffers swap only at vertical blank after the draw engine signals frame completion. Optionally clears the new back buffer after each swap, using only cycles the displayer leaves free. Sits between frame_displayer, the draw engine and the SRAM controller.

---
 rtl/fb_pkg.sv | 14 +
 rtl/frame_buffer_arbiter_if.sv | 22 ++
 rtl/frame_buffer_arbiter_read_pipe.sv | 31 +++
 rtl/frame_buffer_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and arbiter state encoding; frame_displayer
// reuses the geometry constants.
package fb_pkg;
    localparam int ADDR_W       = 19;
    localparam int DATA_W       = 8;
    localparam int FRAME_PIXELS = 307200;
    localparam logic [DATA_W-1:0] CLEAR_COLOR = 8'h00;

    typedef enum logic [1:0] {
        DRAW    = 2'd0,
        WAIT_VS = 2'd1,
        CLEAR   = 2'd2
    } arb_state_e;
endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Draw-engine write handshake and single-port SRAM bus used by the arbiter.
interface fb_draw_if;
    logic                        valid;
    logic                        ready;
    logic [fb_pkg::ADDR_W-1:0]   addr;
    logic [fb_pkg::DATA_W-1:0]   data;
    logic                        frame_done;

    modport master (output valid, addr, data, frame_done, input ready);
    modport slave  (input valid, addr, data, frame_done, output ready);
endinterface

interface fb_mem_if;
    logic [fb_pkg::ADDR_W:0]     addr;
    logic [fb_pkg::DATA_W-1:0]   wdata;
    logic [fb_pkg::DATA_W-1:0]   rdata;
    logic                        we;
    logic                        re;

    modport master (output addr, wdata, we, re, input rdata);
    modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/frame_buffer_arbiter_read_pipe.sv
// Fixed-latency read return path: SRAM data arrives one cycle after the read
// strobe and is presented to the displayer one cycle after that.
module fb_read_pipe
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              re_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic              vld_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            vld_q   <= re_i;
            valid_q <= vld_q;
            if (vld_q) data_q <= rdata_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer owner: displayer reads with strict priority, draw
// engine writes the back buffer, swap at vblank with optional background clear.
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int NPIX = FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_data_valid_o,
    fb_draw_if.slave          draw,
    input  logic              vsync_start_i,
    input  logic              clear_en_i,
    output logic              front_buf_o,
    output logic              busy_o,
    fb_mem_if.master          mem
);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    arb_state_e        state_q, state_d;
    logic              front_q, front_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        clr_cnt_d   = clr_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;

        // One SRAM slot per cycle: display read, then draw write, then clear.
        if (disp_req_i) begin
            mem_re_d   = 1'b1;
            mem_addr_d = {front_q, disp_addr_i};
        end else if (state_q == DRAW && draw.valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {~front_q, draw.addr};
            mem_wdata_d = draw.data;
        end else if (state_q == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {~front_q, clr_cnt_q};
            mem_wdata_d = CLEAR_COLOR;
        end

        case (state_q)
            DRAW: begin
                if (draw.frame_done) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vsync_start_i) begin
                    front_d   = ~front_q;
                    clr_cnt_d = '0;
                    state_d   = clear_en_i ? CLEAR : DRAW;
                end
            end
            CLEAR: begin
                // The clear pointer only advances on cycles that actually wrote.
                if (!disp_req_i) begin
                    if (clr_cnt_q == LAST_PIX) begin
                        clr_cnt_d = '0;
                        state_d   = DRAW;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = DRAW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DRAW;
            front_q     <= 1'b0;
            clr_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            clr_cnt_q   <= clr_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    fb_read_pipe u_read_pipe (
        .clk     (clk),
        .rst     (rst),
        .re_i    (mem_re_q),
        .rdata_i (mem.rdata),
        .data_o  (disp_data_o),
        .valid_o (disp_data_valid_o)
    );

    assign draw.ready  = (state_q == DRAW) & ~disp_req_i & ~rst;
    assign mem.addr    = mem_addr_q;
    assign mem.wdata   = mem_wdata_q;
    assign mem.we      = mem_we_q;
    assign mem.re      = mem_re_q;
    assign front_buf_o = front_q;
    assign busy_o      = (state_q != DRAW);
endmodule
